adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
Round-robin arbiter that shares one sixteenbit_adder instance among NREQ requesters in the MIPS datapath, e.g. PC increment, branch target and ALU add.
- Accepts at most one operand pair per cycle and performs the add combinationally.
- Registers sum, carry and requester ID into a single output stage that uses a valid/ready handshake.
- Guarantees fairness and one-cycle issue-to-result latency when the output is not stalled.

Parameters:
NREQ, 4, number of requesters (2..8)
ID_W, 2, width of requester ID; must satisfy 2**ID_W >= NREQ

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  NREQ  request i has operands ready
req_a  in  NREQ*16  operand A, requester i at bits [16i+15:16i]
req_b  in  NREQ*16  operand B, same packing
req_cin  in  NREQ  carry-in per requester
req_ready  out  NREQ  one-hot grant; request i accepted when req_valid[i] && req_ready[i]
res_valid  out  1  result register holds a valid result
res_ready  in  1  consumer accepts the result this cycle
res_sum  out  16  registered sum
res_cout  out  1  registered carry-out
res_id  out  ID_W  index of the requester that produced the result

Behaviour:
- Reset: sampled on posedge clk while rst_n=0. res_valid=0, res_sum=0, res_cout=0, res_id=0, rr_ptr=0. req_ready is combinational and is 0 during reset.
- Reset mid-operation: a pending result is discarded. No grant is issued in the reset cycle.
- can_issue = !res_valid || res_ready.
- Grant: when can_issue, req_ready is one-hot on the first i with req_valid[i]=1, searching circularly from rr_ptr upward. Otherwise req_ready is all 0.
  - req_ready depends combinationally on req_valid, rr_ptr, res_valid and res_ready. It never depends on operand values.
- Accept cycle (any grant):
  - Adder inputs are req_a[g], req_b[g], req_cin[g].
  - At the next edge: res_sum <= sum, res_cout <= c_out, res_id <= g, res_valid <= 1.
  - rr_ptr <= g+1, wrapping to 0 when g = NREQ-1. Non-power-of-2 NREQ must wrap correctly.
- No grant, res_valid && res_ready: res_valid <= 0. Data registers hold their values, and rr_ptr holds.
- No grant, res_valid && !res_ready: all output registers hold (stall). req_ready stays all 0.
- Simultaneous pop and push (res_valid && res_ready and a grant): the new result replaces the old one in the same edge. Sustained throughput is 1 add/cycle.
- Latency: operands accepted at edge N appear on res_* from edge N+1.
- Fairness: with all requesters continuously valid and res_ready=1, grants cycle 0,1,...,NREQ-1,0. Any requester waits at most NREQ-1 accepts.
- Arithmetic: 16-bit unsigned add with carry-in. res_cout is bit 16 of a+b+cin. No overflow flag.
- Requesters must hold req_a/req_b/req_cin stable while req_valid=1 and not granted. The arbiter does not latch ungranted operands.
- req_valid bits for indices >= NREQ do not exist. res_id never exceeds NREQ-1.

Optional Feature:
Macro ADDER_SUB_EN.
- Defined:
  - Adds port req_sub  in  NREQ.
  - When the granted request has req_sub[g]=1, the adder receives ~req_b[g] and c_in=1, and req_cin[g] is ignored. res_sum = a-b mod 2^16.
  - res_cout = 1 means no borrow (a >= b unsigned).
  - Adds output res_sub  out  1, a registered copy of req_sub[g] that follows the same hold rules as res_*.
- Undefined: req_sub and res_sub ports are absent, and all operations are add.

Test Plan:
- Reset, then req_valid=0001, A=FFFF, B=FFFF, cin=0, res_ready=1 -> req_ready=0001; next cycle res_valid=1, res_sum=FFFE, res_cout=1, res_id=0.
- req_valid=1111 held for 5 cycles, res_ready=1, operands ABCD+AAAA on all requesters -> grants 0,1,2,3,0 in that order; every result has res_sum=5677, res_cout=1.
- Requester 2 sends BEFA+82A6, then res_ready=0 for 3 cycles with req_valid=1111 -> res_sum=41A0, res_cout=1, res_id=2 held stable; req_ready=0000 throughout; after res_ready returns to 1, grant goes to 3.
- NREQ=3, all valid -> grant sequence 0,1,2,0; rr_ptr wraps from 2 to 0; res_id never equals 3.
- rst_n=0 for one cycle while res_valid=1 and res_ready=0 -> next cycle res_valid=0 and rr_ptr=0; the following grant goes to the lowest valid index.
- ADDER_SUB_EN defined: requester 1 sends req_sub=1, A=0010, B=0020 -> res_sum=FFF0, res_cout=0, res_sub=1; then A=0020, B=0010 -> res_sum=0010, res_cout=1.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one 16-bit adder across NREQ requesters.
// Optional ADDER_SUB_EN adds per-request subtract (req_sub/res_sub).
module sixteenbit_adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);
  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {16'd0, c_in};
endmodule

module adder_share_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*16-1:0]   req_a,
  input  logic [NREQ*16-1:0]   req_b,
  input  logic [NREQ-1:0]      req_cin,
  output logic [NREQ-1:0]      req_ready,
`ifdef ADDER_SUB_EN
  input  logic [NREQ-1:0]      req_sub,
  output logic                 res_sub,
`endif
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [15:0]          res_sum,
  output logic                 res_cout,
  output logic [ID_W-1:0]      res_id
);
  localparam int IW = ID_W + 1;
  logic            can_issue, any_v, grant, sub, c_in, c_out;
  logic [IW-1:0]   idx;
  logic [ID_W-1:0] gid;
  logic [15:0]     op_a, op_b, sum;
  logic            res_valid_q, res_valid_d, res_cout_q, res_cout_d;
  logic [15:0]     res_sum_q, res_sum_d;
  logic [ID_W-1:0] res_id_q, res_id_d, rr_q, rr_d;
`ifdef ADDER_SUB_EN
  logic            res_sub_q, res_sub_d;
`endif

  // Scan downward so the lowest circular offset from rr_q wins.
  always_comb begin
    idx = '0;
    gid = '0;
    any_v = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_q} + IW'(k);
      idx = (idx >= IW'(NREQ)) ? idx - IW'(NREQ) : idx;
      if (req_valid[idx[ID_W-1:0]]) begin
        gid = idx[ID_W-1:0];
        any_v = 1'b1;
      end
    end
  end

  assign can_issue = !res_valid_q || res_ready;
  assign grant     = rst_n && can_issue && any_v;
  assign req_ready = grant ? NREQ'(1) << gid : '0;

`ifdef ADDER_SUB_EN
  assign sub = req_sub[gid];
`else
  assign sub = 1'b0;
`endif
  assign op_a = req_a[16*gid +: 16];
  assign op_b = sub ? ~req_b[16*gid +: 16] : req_b[16*gid +: 16];
  assign c_in = sub || req_cin[gid];

  sixteenbit_adder u_add (.a(op_a), .b(op_b), .c_in(c_in), .sum(sum), .c_out(c_out));

  always_comb begin
    res_valid_d = grant || (res_valid_q && !res_ready);
    res_sum_d   = grant ? sum : res_sum_q;
    res_cout_d  = grant ? c_out : res_cout_q;
    res_id_d    = grant ? gid : res_id_q;
    rr_d        = grant ? ((gid == ID_W'(NREQ - 1)) ? '0 : gid + 1'b1) : rr_q;
`ifdef ADDER_SUB_EN
    res_sub_d   = grant ? sub : res_sub_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
      res_id_q    <= '0;
      rr_q        <= '0;
`ifdef ADDER_SUB_EN
      res_sub_q   <= 1'b0;
`endif
    end else begin
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_cout_q  <= res_cout_d;
      res_id_q    <= res_id_d;
      rr_q        <= rr_d;
`ifdef ADDER_SUB_EN
      res_sub_q   <= res_sub_d;
`endif
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_id    = res_id_q;
`ifdef ADDER_SUB_EN
  assign res_sub   = res_sub_q;
`endif
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: randomized and directed checks against a queue-free behavioural model.
module tb_adder_share_arbiter;
  localparam int N = 4;
  logic clk = 1'b0, rst_n = 1'b0, res_ready = 1'b1;
  logic [N-1:0] req_valid = '0, req_cin = '0, req_ready;
  logic [N*16-1:0] req_a = '0, req_b = '0;
  logic res_valid, res_cout;
  logic [15:0] res_sum;
  logic [1:0] res_id;
  logic [2:0] v3 = '0, cin3 = '0, rdy3;
  logic [47:0] a3 = '0, b3 = '0;
  logic rr3_in = 1'b1, rv3, cout3;
  logic [15:0] sum3;
  logic [1:0] id3;
  int checks = 0, errors = 0;
  int m_rr = 0, m_id = 0;
  logic m_v = 1'b0, m_cout = 1'b0;
  logic [15:0] m_sum = '0;

  always #5 clk = ~clk;

  adder_share_arbiter #(.NREQ(N), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_cin(req_cin), .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id));

  adder_share_arbiter #(.NREQ(3), .ID_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_a(a3), .req_b(b3),
    .req_cin(cin3), .req_ready(rdy3), .res_valid(rv3), .res_ready(rr3_in),
    .res_sum(sum3), .res_cout(cout3), .res_id(id3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int exp_grant();
    if (!rst_n || (m_v && !res_ready)) return -1;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  task automatic step();
    int g;
    logic [16:0] s;
    #1;
    g = exp_grant();
    check("req_ready", 32'(req_ready), g < 0 ? 32'd0 : 32'd1 << g);
    check("res_valid", 32'(res_valid), 32'(m_v));
    check("res_sum", 32'(res_sum), 32'(m_sum));
    check("res_cout", 32'(res_cout), 32'(m_cout));
    check("res_id", 32'(res_id), 32'(m_id));
    @(posedge clk);
    if (!rst_n) begin
      m_rr = 0; m_v = 1'b0; m_sum = '0; m_cout = 1'b0; m_id = 0;
    end else if (g >= 0) begin
      s = {1'b0, req_a[16*g +: 16]} + {1'b0, req_b[16*g +: 16]} + 17'(req_cin[g]);
      m_sum = s[15:0]; m_cout = s[16]; m_id = g; m_v = 1'b1; m_rr = (g + 1) % N;
    end else if (m_v && res_ready) m_v = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_all(input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < N; i++) begin
      req_a[16*i +: 16] = a;
      req_b[16*i +: 16] = b;
    end
  endtask

  initial begin
    @(posedge clk);
    @(negedge clk);
    step();
    rst_n = 1'b1; req_valid = 4'b0001; set_all(16'hFFFF, 16'hFFFF); req_cin = '0; res_ready = 1'b1;
    #1 check("tp1_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    check("tp1_valid", 32'(res_valid), 32'h1);
    check("tp1_sum", 32'(res_sum), 32'hFFFE);
    check("tp1_cout", 32'(res_cout), 32'h1);
    check("tp1_id", 32'(res_id), 32'h0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; req_valid = 4'b1111; set_all(16'hABCD, 16'hAAAA);
    for (int i = 0; i < 5; i++) begin
      #1 check("tp2_grant", 32'(req_ready), 32'd1 << (i % 4));
      step();
      check("tp2_sum", 32'(res_sum), 32'h5677);
      check("tp2_cout", 32'(res_cout), 32'h1);
    end
    req_valid = 4'b0100; req_a[47:32] = 16'hBEFA; req_b[47:32] = 16'h82A6;
    step();
    req_valid = 4'b1111; res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("tp3_stall_ready", 32'(req_ready), 32'h0);
      step();
      check("tp3_sum", 32'(res_sum), 32'h41A0);
      check("tp3_cout", 32'(res_cout), 32'h1);
      check("tp3_id", 32'(res_id), 32'h2);
      check("tp3_valid", 32'(res_valid), 32'h1);
    end
    res_ready = 1'b1;
    #1 check("tp3_resume", 32'(req_ready), 32'h8);
    step();
    res_ready = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("tp4_valid", 32'(res_valid), 32'h0);
    req_valid = 4'b0110; res_ready = 1'b1;
    #1 check("tp4_grant", 32'(req_ready), 32'h2);
    step();
    v3 = 3'b111;
    for (int i = 0; i < 4; i++) begin
      #1 check("n3_grant", 32'(rdy3), 32'd1 << (i % 3));
      step();
      check("n3_id", 32'(id3), 32'(i % 3));
    end
    v3 = '0;
    for (int i = 0; i < 500; i++) begin
      rst_n = $urandom_range(0, 31) != 0;
      req_valid = 4'($urandom);
      req_a = {$urandom, $urandom};
      req_b = {$urandom, $urandom};
      req_cin = 4'($urandom);
      res_ready = $urandom_range(0, 3) != 0;
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
